// File: rtl/err_accum16.sv
// err_accum16: windowed error metrics between an exact and an
// approximate 16-bit product (sum, max and mismatch count of |diff|).
module err_accum16 #(
   parameter int N_LOG2 = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   input  logic [15:0]         y_exact,
   input  logic [15:0]         y_appx,
   output logic                busy,
   output logic                done,
   output logic [16+N_LOG2-1:0] err_sum,
   output logic [15:0]         err_max,
   output logic [N_LOG2:0]     mis_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [N_LOG2-1:0] CNT_LAST = '1;

   state_t            state;
   logic [N_LOG2-1:0] cnt;

   logic              v1;
   logic [15:0]       diff1;
   logic              mis1;

   logic [16:0]       d17;
   logic [15:0]       mag;
   logic              accept;
   logic              clr;

   // Combinational magnitude of the 17-bit difference
   always_comb begin
      d17 = {1'b0, y_exact} - {1'b0, y_appx};
      if (d17[16])
         mag = ~d17[15:0] + 16'd1;
      else
         mag = d17[15:0];
   end

   assign accept = (state == RUN) && in_valid;
   assign clr    = (state == IDLE) && start;

   // Window control FSM with registered busy/done
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (in_valid) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Stage 1: capture per-sample error and mismatch flag
   always_ff @(posedge clk) begin
      if (rst) begin
         v1    <= 1'b0;
         diff1 <= '0;
         mis1  <= 1'b0;
      end else if (accept) begin
         v1    <= 1'b1;
         diff1 <= mag;
         mis1  <= (y_exact != y_appx);
      end else begin
         v1    <= 1'b0;
      end
   end

   // Stage 2: fold stage-1 results into the window accumulators
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         err_sum <= '0;
         err_max <= '0;
         mis_cnt <= '0;
      end else if (v1) begin
         err_sum <= err_sum + {{N_LOG2{1'b0}}, diff1};
         if (diff1 > err_max)
            err_max <= diff1;
         mis_cnt <= mis_cnt + {{N_LOG2{1'b0}}, mis1};
      end
   end

endmodule

// File: tb/tb_err_accum16.sv
// tb_err_accum16: directed checks of err_accum16 with N_LOG2=2
// (four-sample windows) and hand-computed expected metrics.
module tb_err_accum16;

   localparam int N = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [15:0]   y_exact = '0;
   logic [15:0]   y_appx = '0;
   logic          busy;
   logic          done;
   logic [17:0]   err_sum;
   logic [15:0]   err_max;
   logic [2:0]    mis_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   int d0;

   err_accum16 #(.N_LOG2(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .y_exact  (y_exact),
      .y_appx   (y_appx),
      .busy     (busy),
      .done     (done),
      .err_sum  (err_sum),
      .err_max  (err_max),
      .mis_cnt  (mis_cnt)
   );

   always #5 clk = ~clk;

   // Count done pulses, sampled mid-cycle
   always @(negedge clk) if (done) n_done++;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [15:0] e, input logic [15:0] a);
      in_valid = 1'b1;
      y_exact  = e;
      y_appx   = a;
      step();
      in_valid = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic res(input string tag, input int s,
                      input int m, input int c);
      chk({tag, "_sum"}, err_sum, s);
      chk({tag, "_max"}, err_max, m);
      chk({tag, "_mis"}, mis_cnt, c);
   endtask

   // After the last feed: check done window, then return in IDLE
   task automatic finish_win(input string tag, input int s,
                             input int m, input int c);
      step();
      chk({tag, "_done"}, done, 1);
      res(tag, s, m, c);
      step();
      chk({tag, "_done_lo"}, done, 0);
      chk({tag, "_busy_lo"}, busy, 0);
   endtask

   initial begin
      // Reset dominates start and in_valid
      rst = 1'b1; start = 1'b1; in_valid = 1'b1;
      y_exact = 16'h1111; y_appx = 16'h2222;
      step(); step();
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      res("rst", 0, 0, 0);

      // Basic window
      d0 = n_done;
      go();
      chk("basic_busy", busy, 1);
      feed(100, 100);
      feed(200, 190);
      feed(300, 310);
      feed(400, 400);
      chk("basic_nodone", done, 0);
      finish_win("basic", 20, 10, 2);
      chk("basic_pulses", n_done - d0, 1);

      // Extremes
      go();
      feed(16'hFFFF, 16'h0000);
      feed(16'h0000, 16'hFFFF);
      feed(16'h8000, 16'h7FFF);
      feed(16'h1234, 16'h1234);
      finish_win("ext", 131071, 65535, 3);

      // Bubbles, start pulsed mid-window
      d0 = n_done;
      go();
      feed(10, 11);
      y_exact = 16'hFFFF; y_appx = 0; step();
      start = 1'b1; step(); start = 1'b0;
      chk("bub_busy", busy, 1);
      feed(20, 22);
      feed(30, 33);
      y_exact = 16'hFFFF; y_appx = 0; step();
      feed(44, 40);
      finish_win("bub", 10, 4, 4);
      chk("bub_pulses", n_done - d0, 1);

      // Reset mid-window
      go();
      feed(0, 900);
      feed(5000, 1);
      rst = 1'b1; step(); rst = 1'b0;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      res("mrst", 0, 0, 0);
      step();
      chk("mrst_idle", busy, 0);
      go();
      for (int i = 0; i < 4; i++) feed(16'(100 * i + 5), 16'(100 * i));
      finish_win("post", 20, 5, 4);

      // IDLE isolation
      for (int i = 0; i < 6; i++) begin
         in_valid = i[0];
         y_exact = 16'($urandom);
         y_appx = 16'($urandom);
         step();
      end
      in_valid = 1'b0;
      chk("iso_busy", busy, 0);
      res("iso", 20, 5, 4);

      // New window after idling
      go();
      feed(1000, 1007);
      feed(50, 50);
      feed(20, 17);
      feed(9, 0);
      finish_win("w2", 19, 9, 3);

      // Start in the first IDLE cycle after done
      go();
      chk("b2b_busy", busy, 1);
      res("b2b_clr", 0, 0, 0);
      feed(100, 100);
      feed(200, 190);
      feed(300, 310);
      feed(400, 400);
      finish_win("b2b", 20, 10, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
